// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared constants for the IF/ID buffer and decode immediate-class check
//
// Purpose : state encoding of the IF/ID reassembly FSM and the instruction
//           class constants shared with the decode stage.
// Contents: S_OP / S_IMM state codes, IMM_CLASS_DEF, NOP_WORD_DEF,
//           has_imm() helper.
package if_id_buffer_pkg;

    // Reassembly FSM: S_OP expects an opcode word, S_IMM expects the
    // immediate word belonging to a pending opcode.
    localparam logic S_OP  = 1'b0;
    localparam logic S_IMM = 1'b1;

    // word[15:13] value marking an opcode followed by an immediate word.
    localparam logic [2:0]  IMM_CLASS_DEF = 3'b101;

    // Instruction presented to decode on a bubble or flush.
    localparam logic [15:0] NOP_WORD_DEF  = 16'h0000;

    function automatic logic has_imm(input logic [15:0] word,
                                     input logic [2:0]  imm_class);
        return word[15:13] == imm_class;
    endfunction

endpackage

// File: rtl/if_id_buffer_imm_class_detect.sv
// rtl/if_id_buffer_imm_class_detect.sv - combinational two-word instruction class detector
//
// Purpose : flags an opcode word whose class field says an immediate word
//           follows. Reused by the decode stage.
// Ports   : word_i    [15:0] candidate opcode word
//           has_imm_o        1 when word_i[15:13] == IMM_CLASS
module imm_class_detect
    import if_id_buffer_pkg::*;
#(
    parameter logic [2:0] IMM_CLASS = IMM_CLASS_DEF
) (
    input  logic [15:0] word_i,
    output logic        has_imm_o
);

    assign has_imm_o = has_imm(word_i, IMM_CLASS);

endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID pipeline register with two-word instruction reassembly
//
// Purpose : registers the fetch word stream for decode, merging an opcode
//           word of class IMM_CLASS with the following immediate word into
//           one {instruction, immediate, pc} bundle. Honours stall and flush.
// Ports   : clk, rst (async active-low)
//           fetchWord[15:0], fetchPc[31:0], fetchValid  - fetch stream
//           stall, flush                                - hazard / redirect
//           idInstruction[15:0], idImmediate[15:0], idPc[31:0], idValid
//                                                       - bundle to decode
//           immPending  - waiting for the immediate word
//           issuedCount[31:0] - bundles emitted with idValid=1 (wraps)
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter logic [2:0]  IMM_CLASS = IMM_CLASS_DEF,
    parameter logic [15:0] NOP_WORD  = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fetchWord,
    input  logic [31:0] fetchPc,
    input  logic        fetchValid,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] idInstruction,
    output logic [15:0] idImmediate,
    output logic [31:0] idPc,
    output logic        idValid,
    output logic        immPending,
    output logic [31:0] issuedCount
);

    logic        state_q, state_d;
    logic [15:0] pend_op_q, pend_op_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [15:0] id_instr_q, id_instr_d;
    logic [15:0] id_imm_q, id_imm_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] issued_count_q, issued_count_d;

    logic        word_has_imm;

    imm_class_detect #(
        .IMM_CLASS (IMM_CLASS)
    ) u_imm_class_detect (
        .word_i    (fetchWord),
        .has_imm_o (word_has_imm)
    );

    always_comb begin
        state_d        = state_q;
        pend_op_d      = pend_op_q;
        pend_pc_d      = pend_pc_q;
        id_instr_d     = id_instr_q;
        id_imm_d       = id_imm_q;
        id_pc_d        = id_pc_q;
        id_valid_d     = id_valid_q;
        issued_count_d = issued_count_q;

        if (flush) begin
            // Kill everything in flight; idPc keeps the last issued PC.
            state_d    = S_OP;
            pend_op_d  = '0;
            pend_pc_d  = '0;
            id_valid_d = 1'b0;
            id_instr_d = NOP_WORD;
            id_imm_d   = '0;
        end else if (!stall) begin
            // Default for a non-stalled cycle is a bubble.
            id_valid_d = 1'b0;
            if (fetchValid) begin
                if (state_q == S_IMM) begin
                    // Word is the immediate regardless of its class bits.
                    id_instr_d     = pend_op_q;
                    id_imm_d       = fetchWord;
                    id_pc_d        = pend_pc_q;
                    id_valid_d     = 1'b1;
                    issued_count_d = issued_count_q + 32'd1;
                    state_d        = S_OP;
                end else if (word_has_imm) begin
                    pend_op_d = fetchWord;
                    pend_pc_d = fetchPc;
                    state_d   = S_IMM;
                end else begin
                    id_instr_d     = fetchWord;
                    id_imm_d       = '0;
                    id_pc_d        = fetchPc;
                    id_valid_d     = 1'b1;
                    issued_count_d = issued_count_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_OP;
            pend_op_q      <= '0;
            pend_pc_q      <= '0;
            id_instr_q     <= NOP_WORD;
            id_imm_q       <= '0;
            id_pc_q        <= '0;
            id_valid_q     <= 1'b0;
            issued_count_q <= '0;
        end else begin
            state_q        <= state_d;
            pend_op_q      <= pend_op_d;
            pend_pc_q      <= pend_pc_d;
            id_instr_q     <= id_instr_d;
            id_imm_q       <= id_imm_d;
            id_pc_q        <= id_pc_d;
            id_valid_q     <= id_valid_d;
            issued_count_q <= issued_count_d;
        end
    end

    assign idInstruction = id_instr_q;
    assign idImmediate   = id_imm_q;
    assign idPc          = id_pc_q;
    assign idValid       = id_valid_q;
    assign immPending    = (state_q == S_IMM);
    assign issuedCount   = issued_count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - self-checking bench for if_id_buffer
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fetchWord = '0;
    logic [31:0] fetchPc = '0;
    logic        fetchValid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] idInstruction;
    logic [15:0] idImmediate;
    logic [31:0] idPc;
    logic        idValid;
    logic        immPending;
    logic [31:0] issuedCount;

    int tests = 0;
    int fails = 0;

    // Reference model: what decode should currently see, plus a
    // "half-received two-word instruction" record.
    logic [15:0] m_instr;
    logic [15:0] m_imm;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_count;
    logic        m_have_op;
    logic [15:0] m_op;
    logic [31:0] m_op_pc;

    if_id_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .fetchWord     (fetchWord),
        .fetchPc       (fetchPc),
        .fetchValid    (fetchValid),
        .stall         (stall),
        .flush         (flush),
        .idInstruction (idInstruction),
        .idImmediate   (idImmediate),
        .idPc          (idPc),
        .idValid       (idValid),
        .immPending    (immPending),
        .issuedCount   (issuedCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instr"},   {16'h0, idInstruction}, {16'h0, m_instr});
        check({tag, ".imm"},     {16'h0, idImmediate},   {16'h0, m_imm});
        check({tag, ".pc"},      idPc,                   m_pc);
        check({tag, ".valid"},   {31'h0, idValid},       {31'h0, m_valid});
        check({tag, ".pending"}, {31'h0, immPending},    {31'h0, m_have_op});
        check({tag, ".count"},   issuedCount,            m_count);
    endtask

    task automatic model_reset();
        m_instr = 16'h0000; m_imm = '0; m_pc = '0; m_valid = 1'b0;
        m_count = '0; m_have_op = 1'b0; m_op = '0; m_op_pc = '0;
    endtask

    task automatic emit(input logic [15:0] ins, input logic [15:0] imm, input logic [31:0] pc);
        m_instr = ins; m_imm = imm; m_pc = pc; m_valid = 1'b1;
        m_count = m_count + 32'd1;
    endtask

    // One clock: drive inputs, advance the model, check 1 time unit after the edge.
    task automatic step(input string tag, input logic [15:0] w, input logic [31:0] pc,
                        input logic v, input logic st, input logic fl);
        fetchWord = w; fetchPc = pc; fetchValid = v; stall = st; flush = fl;
        if (fl) begin
            m_have_op = 1'b0; m_valid = 1'b0; m_instr = 16'h0000; m_imm = '0;
        end else if (!st) begin
            m_valid = 1'b0;
            if (v) begin
                if (m_have_op) begin
                    emit(m_op, w, m_op_pc);
                    m_have_op = 1'b0;
                end else if (w[15:13] == 3'b101) begin
                    m_have_op = 1'b1; m_op = w; m_op_pc = pc;
                end else begin
                    emit(w, 16'h0000, pc);
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset_state");
        @(negedge clk);
        rst = 1'b1;

        // Get a valid bundle, then reset asynchronously mid-cycle.
        step("pre_reset", 16'h4321, 32'd1, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b1;
        step("after_reset", 16'h1234, 32'd5, 1'b1, 1'b0, 1'b0);

        // Two-word instruction.
        step("two_word_op",  16'hA003, 32'd8, 1'b1, 1'b0, 1'b0);
        step("two_word_imm", 16'h00FF, 32'd9, 1'b1, 1'b0, 1'b0);

        // Stall while waiting for the immediate.
        step("stall_op", 16'hA00C, 32'd20, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("stall_hold", (i[0] ? 16'hFFFF : 16'h5555), 32'd21 + i, 1'b1, 1'b1, 1'b0);
        step("stall_release", 16'h0077, 32'd21, 1'b1, 1'b0, 1'b0);

        // Bubble does not disturb a completed bundle except idValid.
        step("bubble", 16'h1111, 32'd30, 1'b0, 1'b0, 1'b0);

        // Flush with stall while pending.
        step("flush_op",     16'hA003, 32'd40, 1'b1, 1'b0, 1'b0);
        step("flush_stall",  16'hBEEF, 32'd41, 1'b1, 1'b1, 1'b1);
        step("flush_next",   16'h2222, 32'd42, 1'b1, 1'b0, 1'b0);

        // Immediate whose bits match IMM_CLASS.
        step("immcls_op",   16'hA001, 32'd50, 1'b1, 1'b0, 1'b0);
        step("immcls_imm",  16'hA7FF, 32'd51, 1'b1, 1'b0, 1'b0);
        step("immcls_next", 16'h0001, 32'd52, 1'b1, 1'b0, 1'b0);

        // Reset while pending: opcode dropped.
        step("rst_pend_op", 16'hB000, 32'd60, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst_pend_cleared");
        @(negedge clk);
        rst = 1'b1;
        step("rst_pend_next", 16'h0300, 32'd61, 1'b1, 1'b0, 1'b0);

        // Counter wrap.
        force dut.issued_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.issued_count_q;
        m_count = 32'hFFFF_FFFF;
        step("wrap_issue",  16'h0042, 32'd70, 1'b1, 1'b0, 1'b0);
        step("wrap_bubble", 16'h0043, 32'd71, 1'b0, 1'b0, 1'b0);
        step("wrap_flush",  16'h0044, 32'd72, 1'b1, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:13] = 3'b101;
            step("random", w, $urandom,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 8);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
